// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the RV32I datapath.
// The controller side is the master: it reads IR fields and handshakes and drives every enable.
interface multicycle_controller_if #(
  parameter int OP_WIDTH       = 7,
  parameter int FUNCT3_WIDTH   = 3,
  parameter int ALU_CTRL_WIDTH = 3,
  parameter int IMM_SRC_WIDTH  = 2,
  parameter int CNT_WIDTH      = 32
);
  logic [OP_WIDTH-1:0]       op;
  logic [FUNCT3_WIDTH-1:0]   funct3;
  logic                      funct7_5;
  logic                      Zero;
  logic                      mem_ready;
  logic                      PCWrite;
  logic                      AdrSrc;
  logic                      MemWrite;
  logic                      IRWrite;
  logic [1:0]                ResultSrc;
  logic [1:0]                ALUSrcA;
  logic [1:0]                ALUSrcB;
  logic [ALU_CTRL_WIDTH-1:0] ALUControl;
  logic [IMM_SRC_WIDTH-1:0]  ImmSrc;
  logic                      RegWrite;
  logic                      illegal_op;
  logic [CNT_WIDTH-1:0]      instret;

  modport master (
    input  op, funct3, funct7_5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, illegal_op, instret
  );

  modport slave (
    output op, funct3, funct7_5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, illegal_op, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the single-memory-port, single-ALU RV32I core.
// Only the state and the retired-instruction counter are registered; every control output is decoded combinationally.
module multicycle_controller #(
  parameter int OP_WIDTH       = 7,
  parameter int FUNCT3_WIDTH   = 3,
  parameter int ALU_CTRL_WIDTH = 3,
  parameter int IMM_SRC_WIDTH  = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master ctrl
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL
  } state_e;

  localparam logic [OP_WIDTH-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_WIDTH-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_WIDTH-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_WIDTH-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_WIDTH-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_WIDTH-1:0] OP_JAL    = 7'b1101111;

  state_e                    state_q, state_d;
  logic [CNT_WIDTH-1:0]      instret_q, instret_d;
  logic                      retire;
  logic                      pcWrite, irWrite, memWrite, regWrite, adrSrc, illegalOp;
  logic [1:0]                resultSrc, aluSrcA, aluSrcB;
  logic [ALU_CTRL_WIDTH-1:0] aluControl, aluFunc;
  logic [IMM_SRC_WIDTH-1:0]  immSrc;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (ctrl.mem_ready) state_d = DECODE;
      DECODE: begin
        case (ctrl.op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECUTER;
          OP_ITYPE:          state_d = EXECUTEI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          default:           state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = ctrl.op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (ctrl.mem_ready) state_d = MEMWB;
      MEMWRITE: if (ctrl.mem_ready) state_d = FETCH;
      EXECUTER, EXECUTEI: state_d = ALUWB;
      JAL:      state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  // A store retires only on the cycle its single write is accepted.
  assign retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BRANCH) ||
                  ((state_q == MEMWRITE) && ctrl.mem_ready);
  assign instret_d = retire ? instret_q + CNT_WIDTH'(1) : instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    aluFunc = 3'b000;
    case (ctrl.funct3)
      3'b000:  aluFunc = (ctrl.funct7_5 && ctrl.op[5]) ? 3'b001 : 3'b000;
      3'b010:  aluFunc = 3'b101;
      3'b110:  aluFunc = 3'b011;
      3'b111:  aluFunc = 3'b010;
      default: aluFunc = 3'b000;
    endcase
  end

  always_comb begin
    immSrc = 2'b00;
    case (ctrl.op)
      OP_STORE:  immSrc = 2'b01;
      OP_BRANCH: immSrc = 2'b10;
      OP_JAL:    immSrc = 2'b11;
      default:   immSrc = 2'b00;
    endcase
  end

  always_comb begin
    pcWrite    = 1'b0;
    irWrite    = 1'b0;
    memWrite   = 1'b0;
    regWrite   = 1'b0;
    adrSrc     = 1'b0;
    illegalOp  = 1'b0;
    resultSrc  = 2'b00;
    aluSrcA    = 2'b00;
    aluSrcB    = 2'b00;
    aluControl = 3'b000;
    case (state_q)
      FETCH: begin
        aluSrcB   = 2'b10;
        resultSrc = 2'b10;
        pcWrite   = ctrl.mem_ready;
        irWrite   = ctrl.mem_ready;
      end
      DECODE: begin
        aluSrcA   = 2'b01;
        aluSrcB   = 2'b01;
        illegalOp = (state_d == FETCH);
      end
      MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
      end
      MEMREAD:  adrSrc = 1'b1;
      MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
      end
      MEMWRITE: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
      end
      EXECUTER: begin
        aluSrcA    = 2'b10;
        aluControl = aluFunc;
      end
      EXECUTEI: begin
        aluSrcA    = 2'b10;
        aluSrcB    = 2'b01;
        aluControl = aluFunc;
      end
      ALUWB:    regWrite = 1'b1;
      BRANCH: begin
        aluSrcA    = 2'b10;
        aluControl = 3'b001;
        if (ctrl.funct3 == 3'b000)      pcWrite = ctrl.Zero;
        else if (ctrl.funct3 == 3'b001) pcWrite = !ctrl.Zero;
      end
      JAL: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b10;
        pcWrite = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are gated by reset so an abandoned instruction can never commit.
  assign ctrl.PCWrite    = pcWrite & rst_n;
  assign ctrl.IRWrite    = irWrite & rst_n;
  assign ctrl.MemWrite   = memWrite & rst_n;
  assign ctrl.RegWrite   = regWrite & rst_n;
  assign ctrl.AdrSrc     = adrSrc;
  assign ctrl.ResultSrc  = resultSrc;
  assign ctrl.ALUSrcA    = aluSrcA;
  assign ctrl.ALUSrcB    = aluSrcB;
  assign ctrl.ALUControl = aluControl;
  assign ctrl.ImmSrc     = immSrc;
  assign ctrl.illegal_op = illegalOp;
  assign ctrl.instret    = instret_q;

endmodule
